pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Merges per-stage stall requests into the shared stall_ctrl[5:0] vector that every pipeline register consumes.
- Sequences exception and ERET redirects through a two-cycle freeze-then-flush FSM, and supplies the redirect PC to the PC stage.
- Provides a memory-stall timeout detector and a stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 96 +++++++++
 tb/tb_pipe_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences exception/ERET
// redirects through a freeze-then-flush FSM, and tracks memory-stall health.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic                 excp_valid,
  input  logic                 excp_eret,
  input  logic [31:0]          cp0_epc,
  output logic [5:0]           stall_ctrl,
  output logic                 flush,
  output logic [31:0]          new_pc,
  output logic                 bus_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int unsigned TCNT_W = 16;
  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(STALL_TIMEOUT);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t               r_state;
  logic [TCNT_W-1:0]    r_tcnt;
  logic                 r_flush;
  logic [31:0]          r_new_pc;
  logic                 r_bus_timeout;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [5:0]           w_stall;
  logic [TCNT_W-1:0]    w_tcnt_inc;

  assign w_tcnt_inc = r_tcnt + TCNT_W'(1);

  // Highest requesting stage wins; an exception freezes up to MEM/WB so the
  // excepting instruction bubbles into WB. Forced low while in reset.
  always_comb begin
    w_stall = 6'b000000;
    if (!rst && r_state == S_RUN) begin
      if (excp_valid)        w_stall = 6'b011111;
      else if (stallreq_mem) w_stall = 6'b011111;
      else if (stallreq_ex)  w_stall = 6'b001111;
      else if (stallreq_id)  w_stall = 6'b000111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_tcnt         <= '0;
      r_flush        <= 1'b0;
      r_new_pc       <= '0;
      r_bus_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_flush       <= 1'b0;
      r_bus_timeout <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (excp_valid) begin
            r_state  <= S_FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= excp_eret ? cp0_epc : EXC_VECTOR;
          end
          if (!stallreq_mem) begin
            r_tcnt <= '0;
          end else if (w_tcnt_inc == TCNT_LIMIT) begin
            r_tcnt        <= '0;
            r_bus_timeout <= 1'b1;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end
        S_FLUSH: begin
          r_state <= S_RUN;
          r_tcnt  <= '0;
        end
        default: r_state <= S_RUN;
      endcase
      // Saturating performance counter of PC-stage stall cycles
      if (w_stall[0] && (r_stall_cycles != {CNT_WIDTH{1'b1}}))
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
    end
  end

  assign stall_ctrl   = w_stall;
  assign flush        = r_flush;
  assign new_pc       = r_new_pc;
  assign bus_timeout  = r_bus_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, excp_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall_ctrl, s_stall_ctrl;
  logic        flush, s_flush;
  logic [31:0] new_pc, s_new_pc;
  logic        bus_timeout, s_bus_timeout;
  logic [31:0] stall_cycles;
  logic [2:0]  s_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_tcnt;
  bit          m_tout;
  longint      m_cycles;
  int          tout_seen;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .STALL_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem), .excp_valid(excp_valid), .excp_eret(excp_eret),
    .cp0_epc(cp0_epc), .stall_ctrl(stall_ctrl), .flush(flush), .new_pc(new_pc),
    .bus_timeout(bus_timeout), .stall_cycles(stall_cycles));

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .STALL_TIMEOUT(4), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem), .excp_valid(excp_valid), .excp_eret(excp_eret),
    .cp0_epc(cp0_epc), .stall_ctrl(s_stall_ctrl), .flush(s_flush), .new_pc(s_new_pc),
    .bus_timeout(s_bus_timeout), .stall_cycles(s_stall_cycles));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush = 0; m_pc = '0; m_tcnt = 0; m_tout = 0; m_cycles = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input bit id, input bit ex, input bit mem, input bit ev,
                      input bit er, input logic [31:0] epc);
    int          nb;
    logic [5:0]  exp_stall;
    longint      sat;
    @(negedge clk);
    stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excp_valid = ev; excp_eret = er; cp0_epc = epc;
    #1;
    if (m_flush)   nb = 0;
    else if (ev)   nb = 5;
    else if (mem)  nb = 5;
    else if (ex)   nb = 4;
    else if (id)   nb = 3;
    else           nb = 0;
    exp_stall = 6'((1 << nb) - 1);
    sat = (m_cycles > 7) ? 7 : m_cycles;
    check_eq("stall_ctrl",    64'(stall_ctrl),     64'(exp_stall));
    check_eq("flush",         64'(flush),          64'(m_flush));
    check_eq("new_pc",        64'(new_pc),         64'(m_pc));
    check_eq("bus_timeout",   64'(bus_timeout),    64'(m_tout));
    check_eq("stall_cycles",  64'(stall_cycles),   64'(m_cycles));
    check_eq("sat_cycles",    64'(s_stall_cycles), 64'(sat));
    if (bus_timeout) tout_seen++;
    // Advance model to the next cycle
    m_tout = 0;
    if (m_flush) begin
      m_flush = 0;
      m_tcnt  = 0;
    end else begin
      if (mem) begin
        m_tcnt++;
        if (m_tcnt == 4) begin m_tout = 1; m_tcnt = 0; end
      end else begin
        m_tcnt = 0;
      end
      if (ev) begin
        m_flush = 1;
        m_pc    = er ? epc : 32'h0000_0020;
      end
    end
    if (exp_stall[0]) m_cycles++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_eret} = '0;
    cp0_epc = '0;
    model_reset();
    #2;
    check_eq("rst_stall",   64'(stall_ctrl),   64'd0);
    check_eq("rst_flush",   64'(flush),        64'd0);
    check_eq("rst_new_pc",  64'(new_pc),       64'd0);
    check_eq("rst_timeout", 64'(bus_timeout),  64'd0);
    check_eq("rst_cycles",  64'(stall_cycles), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Counter: 5 ID stalls plus one exception freeze -> 6
    repeat (5) step(1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    check_eq("exc_flush",  64'(flush),  64'd1);
    check_eq("exc_vector", 64'(new_pc), 64'h20);
    check_eq("cnt_six",    64'(stall_cycles), 64'd6);
    step(0, 0, 0, 0, 0, '0);
    check_eq("exc_flush_low", 64'(flush), 64'd0);

    // Priority merge and saturation of the 3-bit counter
    step(1, 0, 0, 0, 0, '0);
    step(1, 1, 0, 0, 0, '0);
    step(1, 1, 1, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    repeat (10) step(1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    check_eq("sat_held", 64'(s_stall_cycles), 64'd7);

    // ERET with concurrent memory stall; excp_valid held in FLUSH is ignored
    step(0, 0, 1, 1, 1, 32'hBFC0_0100);
    step(0, 0, 1, 1, 1, 32'h1234_5678);
    check_eq("eret_pc", 64'(new_pc), 64'hBFC0_0100);
    step(0, 0, 0, 0, 0, '0);
    check_eq("eret_single_flush", 64'(flush), 64'd0);

    // Timeout: 10 memory-stall cycles -> two pulses
    tout_seen = 0;
    repeat (10) step(0, 0, 1, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    check_eq("timeout_pulses", 64'(tout_seen), 64'd2);

    // Async reset during the FLUSH cycle
    step(0, 1, 0, 1, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    #1;
    check_eq("arst_flush",  64'(flush),      64'd0);
    check_eq("arst_stall",  64'(stall_ctrl), 64'd0);
    check_eq("arst_new_pc", 64'(new_pc),     64'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    step(0, 0, 0, 0, 0, '0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), 1'($urandom), $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
